// File: rtl/vit_dec_param_if.sv
// vit_dec_param_if: symbol-in / frame-out bundle for the parametrised Viterbi decoder.
// Signals: rx, seq_rdy (source -> decoder); data_ack, dec_data, dec_valid, dec_metric, busy (decoder -> sink).
// master = source/sink side, slave = decoder side; FRAME_SYMS and MW must match the decoder instance.
interface vit_dec_param_if #(
  parameter int FRAME_SYMS = 12,
  parameter int MW         = 6
) ();
  logic [1:0]            rx;
  logic                  seq_rdy;
  logic                  data_ack;
  logic [FRAME_SYMS-1:0] dec_data;
  logic                  dec_valid;
  logic [MW-1:0]         dec_metric;
  logic                  busy;

  modport master (
    output rx, seq_rdy,
    input  data_ack, dec_data, dec_valid, dec_metric, busy
  );

  modport slave (
    input  rx, seq_rdy,
    output data_ack, dec_data, dec_valid, dec_metric, busy
  );
endinterface

// File: rtl/vit_dec_param.sv
// vit_dec_param: hard-decision rate-1/2 Viterbi decoder, parallel ACS on 2^(K-1) states, register-exchange survivors.
// Latency: at most one symbol per 2 cycles; dec_valid 2 cycles after the last data_ack (3 with VITDEC_BEST_STATE_EN).
// Backpressure: waits in SAMP while seq_rdy=0 (no timeout); the data_ack pulse tells the source to advance rx.
// Ports: clk, rst (async, active-high); bus (vit_dec_param_if.slave): rx, seq_rdy in;
//        data_ack, dec_data (MSB = first bit), dec_valid, dec_metric, busy out.
// Optional macro VITDEC_BEST_STATE_EN: emit the minimum-metric state (for unterminated frames) instead of state 0.
module vit_dec_param #(
  parameter int K          = 3,
  parameter int G0         = 7,
  parameter int G1         = 5,
  parameter int FRAME_SYMS = 12,
  parameter int MW         = 6
) (
  input  logic           clk,
  input  logic           rst,
  vit_dec_param_if.slave bus
);
  localparam int SW = K - 1;
  localparam int NS = 1 << SW;
  localparam int CW = $clog2(FRAME_SYMS + 1);
  localparam logic [K-1:0]  L_G0   = G0[K-1:0];
  localparam logic [K-1:0]  L_G1   = G1[K-1:0];
  localparam logic [MW-1:0] L_MAX  = {MW{1'b1}};
  localparam logic [CW-1:0] L_LAST = CW'(FRAME_SYMS);

  typedef enum logic [2:0] {S_IDLE, S_SAMP, S_WAIT, S_BEST, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MW-1:0]         r_pm   [NS];
  logic [FRAME_SYMS-1:0] r_surv [NS];
  logic [CW-1:0]         r_sym_cnt;
  logic                  r_data_ack;
  logic                  r_dec_valid;
  logic                  r_busy;
  logic [FRAME_SYMS-1:0] r_dec_data;
  logic [MW-1:0]         r_dec_metric;

  logic                  w_acc;
  logic                  w_fin;
  logic [MW-1:0]         w_m0       [NS];
  logic [MW-1:0]         w_m1       [NS];
  logic [MW-1:0]         w_pm_nxt   [NS];
  logic [FRAME_SYMS-1:0] w_surv_nxt [NS];
  logic [FRAME_SYMS-1:0] w_sel_surv;
  logic [MW-1:0]         w_sel_pm;

  // Predecessor of state n: drop the newest bit (MSB), shift left, x becomes the oldest bit.
  function automatic logic [SW-1:0] f_pred(input int n, input logic x);
    logic [SW-1:0] nb;
    nb = SW'(n);
    return {nb[SW-2:0], x};
  endfunction

  // Hamming distance between the received symbol and the branch output.
  // The encoder register {b, p} equals {n, x}: b is the MSB of n, p is {n[SW-2:0], x}.
  function automatic logic [1:0] f_bm(input logic [1:0] sym, input int n, input logic x);
    logic [K-1:0] r;
    logic [1:0]   d;
    r = {SW'(n), x};
    d = sym ^ {^(r & L_G0), ^(r & L_G1)};
    return {d[1] & d[0], d[1] ^ d[0]};
  endfunction

  function automatic logic [MW-1:0] f_sat_add(input logic [MW-1:0] a, input logic [1:0] b);
    logic [MW:0] s;
    s = {1'b0, a} + {{(MW-1){1'b0}}, b};
    return s[MW] ? L_MAX : s[MW-1:0];
  endfunction

  // ---------------------------------------------------------------- ACS
  always_comb begin
    for (int n = 0; n < NS; n++) begin
      w_m0[n] = f_sat_add(r_pm[f_pred(n, 1'b0)], f_bm(bus.rx, n, 1'b0));
      w_m1[n] = f_sat_add(r_pm[f_pred(n, 1'b1)], f_bm(bus.rx, n, 1'b1));
      // Strict compare: a tie keeps the predecessor whose oldest bit is 0.
      if (w_m1[n] < w_m0[n]) begin
        w_pm_nxt[n]   = w_m1[n];
        w_surv_nxt[n] = {r_surv[f_pred(n, 1'b1)][FRAME_SYMS-2:0], 1'(n >> (SW - 1))};
      end else begin
        w_pm_nxt[n]   = w_m0[n];
        w_surv_nxt[n] = {r_surv[f_pred(n, 1'b0)][FRAME_SYMS-2:0], 1'(n >> (SW - 1))};
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.seq_rdy) w_state_nxt = S_SAMP;
      S_SAMP: if (bus.seq_rdy) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_sym_cnt == L_LAST)
`ifdef VITDEC_BEST_STATE_EN
          w_state_nxt = S_BEST;
`else
          w_state_nxt = S_DONE;
`endif
        else
          w_state_nxt = S_SAMP;
      end
      S_BEST:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc = (r_state == S_SAMP) && bus.seq_rdy;
    w_fin = (r_state == S_DONE);
  end

  // ---------------------------------------------------------------- final state selection
`ifdef VITDEC_BEST_STATE_EN
  logic [SW-1:0]         w_min_idx;
  logic [MW-1:0]         w_min_pm;
  logic [FRAME_SYMS-1:0] r_best_surv;
  logic [MW-1:0]         r_best_pm;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_min_idx = '0;
    w_min_pm  = r_pm[0];
    for (int s = 1; s < NS; s++) begin
      if (r_pm[s] < w_min_pm) begin
        w_min_pm  = r_pm[s];
        w_min_idx = SW'(s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_surv <= '0;
      r_best_pm   <= '0;
    end else if (r_state == S_BEST) begin
      r_best_surv <= r_surv[w_min_idx];
      r_best_pm   <= w_min_pm;
    end
  end

  assign w_sel_surv = r_best_surv;
  assign w_sel_pm   = r_best_pm;
`else
  assign w_sel_surv = r_surv[0];
  assign w_sel_pm   = r_pm[0];
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        r_pm[s]   <= (s == 0) ? '0 : L_MAX;
        r_surv[s] <= '0;
      end
      r_sym_cnt    <= '0;
      r_data_ack   <= 1'b0;
      r_dec_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_dec_data   <= '0;
      r_dec_metric <= '0;
    end else begin
      r_data_ack  <= w_acc;
      r_dec_valid <= w_fin;
      if (w_acc) begin
        for (int s = 0; s < NS; s++) begin
          r_pm[s]   <= w_pm_nxt[s];
          r_surv[s] <= w_surv_nxt[s];
        end
        r_sym_cnt <= r_sym_cnt + 1'b1;
        r_busy    <= 1'b1;
      end
      if (w_fin) begin
        r_dec_data   <= w_sel_surv;
        r_dec_metric <= w_sel_pm;
        r_busy       <= 1'b0;
        r_sym_cnt    <= '0;
        // Start the next frame from the known all-zero encoder state.
        for (int s = 0; s < NS; s++) begin
          r_pm[s]   <= (s == 0) ? '0 : L_MAX;
          r_surv[s] <= '0;
        end
      end
    end
  end

  assign bus.data_ack   = r_data_ack;
  assign bus.dec_valid  = r_dec_valid;
  assign bus.busy       = r_busy;
  assign bus.dec_data   = r_dec_data;
  assign bus.dec_metric = r_dec_metric;
endmodule
